branch_predictor: RTL
=====================

// Module: branch_predictor
// PURPOSE
// - Parametrised fetch-stage predictor; successor to the fixed 2-wide opcode-only stage.
// - Sits between the icache return and the instruction buffer.
// - Per-slot 2-bit saturating BHT plus direct-mapped tagged BTB, trained by a backend update port.
// - Registers the fetch group, masks slots after a predicted-taken branch, redirects the PC.
// PARAMETERS
// - FETCH_WIDTH  2    instructions per fetch group, 1..4
// - BHT_DEPTH    256  BHT entries, power of 2
// - BTB_DEPTH    64   BTB entries, power of 2
// - TAG_W        10   BTB tag bits
// PORTS
// - clk              in   1              clock
// - rst              in   1              async reset, active high
// - branch_flush     in   1              backend redirect; kill the registered group
// - stall_i          in   1              downstream full; hold outputs, ignore inputs
// - pc_i             in   32             PC of slot 0, word aligned; slot i PC = pc_i+4*i
// - inst_i           in   32*FETCH_WIDTH slot i at [32i+31:32i]
// - inst_valid_i     in   FETCH_WIDTH    slot valid mask
// - excp_i           in   1              fetch exception for the group
// - excp_cause_i     in   7              exception cause
// - upd_en_i         in   1              resolved-branch update strobe
// - upd_pc_i         in   32             PC of resolved branch
// - upd_taken_i      in   1              actual direction
// - upd_target_i     in   32             actual target
// - inst_o           out  32*FETCH_WIDTH registered instructions
// - pc_o             out  32*FETCH_WIDTH registered PCs
// - valid_o          out  FETCH_WIDTH    registered, post-mask valid
// - is_branch_o      out  FETCH_WIDTH    slot opcode[31:26] in 6'b010010..6'b011011
// - excp_o           out  1              registered exception flag
// - excp_cause_o     out  7              registered exception cause
// - pre_taken_o      out  1              group predicted taken
// - pre_slot_o       out  $clog2(FETCH_WIDTH)+1  taken slot index; 0 when not taken
// - pre_branch_addr  out  32             redirect target, else pc+4*FETCH_WIDTH
// BEHAVIOUR
// - Reset (async): all outputs 0; every BHT counter 2'b01 (weakly not-taken); all BTB valid bits 0.
// - Indexing:
//   - BHT idx = pc[log2(BHT_DEPTH)+1:2].
//   - BTB idx = pc[log2(BTB_DEPTH)+1:2].
//   - BTB tag = pc[TAG_W+log2(BTB_DEPTH)+1 : log2(BTB_DEPTH)+2].
// - Slot predicted taken when all hold: valid, is_branch, BHT[idx][1]==1, BTB valid, BTB tag match, !excp_i.
// - The lowest predicted-taken slot k wins:
//   - pre_taken_o=1, pre_slot_o=k, pre_branch_addr = BTB target of slot k.
//   - valid_o[j]=0 for all j>k.
// - No taken slot: pre_taken_o=0, pre_branch_addr = pc_i + 4*FETCH_WIDTH (32-bit wrap).
// - Latency 1: lookup is combinational on the inputs; all outputs are registered at posedge.
// - stall_i=1: every output register holds; inputs are ignored.
// - branch_flush=1: next edge clears valid_o, is_branch_o, pre_taken_o, excp_o.
//   - Flush has priority over stall; the tables are untouched.
// - Update, independent of stall and flush:
//   - upd_en: BHT counter +1 if taken, -1 if not taken, saturating at 0 and 3.
//   - upd_en with upd_taken: BTB entry <= {valid=1, tag, upd_target_i}.
//   - Not-taken updates leave the BTB unchanged.
// - Same-cycle update and lookup of one entry: the lookup sees the old value (read-before-write).
// - Two slots mapping to the same entry both read the same value.
// TESTING
// - Reset, pc_i=0x1c000000, both slots beq -> pre_taken_o=0, pre_branch_addr=0x1c000008, valid_o=2'b11.
// - 2x upd_en(pc 0x1c000004, taken, target 0x1c000100), then fetch 0x1c000000:
//   slot1 taken, pre_slot_o=1, addr=0x1c000100.
// - Slot0 trained taken, slot1 valid -> valid_o=2'b01, pre_slot_o=0.
// - Counter at 3, 5x not-taken updates -> counter 0; 5x taken -> 3; no wrap.
// - stall_i held 3 cycles with changing inputs -> outputs frozen; flush+stall same cycle -> valid_o=0 next edge.
// - rst asserted mid-stream between edges -> outputs 0 immediately; prior training lost (prediction not taken).

Source files
------------

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch-group, update and prediction signals of the branch predictor
interface branch_predictor_if #(
    parameter int FETCH_WIDTH = 2
);
    localparam int SLOT_W = $clog2(FETCH_WIDTH) + 1;

    logic                     branch_flush;
    logic                     stall_i;
    logic [31:0]              pc_i;
    logic [32*FETCH_WIDTH-1:0] inst_i;
    logic [FETCH_WIDTH-1:0]   inst_valid_i;
    logic                     excp_i;
    logic [6:0]               excp_cause_i;
    logic                     upd_en_i;
    logic [31:0]              upd_pc_i;
    logic                     upd_taken_i;
    logic [31:0]              upd_target_i;

    logic [32*FETCH_WIDTH-1:0] inst_o;
    logic [32*FETCH_WIDTH-1:0] pc_o;
    logic [FETCH_WIDTH-1:0]   valid_o;
    logic [FETCH_WIDTH-1:0]   is_branch_o;
    logic                     excp_o;
    logic [6:0]               excp_cause_o;
    logic                     pre_taken_o;
    logic [SLOT_W-1:0]        pre_slot_o;
    logic [31:0]              pre_branch_addr;

    modport master (
        output branch_flush, stall_i, pc_i, inst_i, inst_valid_i, excp_i, excp_cause_i,
               upd_en_i, upd_pc_i, upd_taken_i, upd_target_i,
        input  inst_o, pc_o, valid_o, is_branch_o, excp_o, excp_cause_o,
               pre_taken_o, pre_slot_o, pre_branch_addr
    );

    modport slave (
        input  branch_flush, stall_i, pc_i, inst_i, inst_valid_i, excp_i, excp_cause_i,
               upd_en_i, upd_pc_i, upd_taken_i, upd_target_i,
        output inst_o, pc_o, valid_o, is_branch_o, excp_o, excp_cause_o,
               pre_taken_o, pre_slot_o, pre_branch_addr
    );
endinterface

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - fetch-stage predictor: 2-bit BHT + tagged BTB, registered fetch group
module branch_predictor #(
    parameter int FETCH_WIDTH = 2,
    parameter int BHT_DEPTH   = 256,
    parameter int BTB_DEPTH   = 64,
    parameter int TAG_W       = 10
) (
    input  logic               clk,
    input  logic               rst,
    branch_predictor_if.slave  bus
);
    localparam int BHT_IW = $clog2(BHT_DEPTH);
    localparam int BTB_IW = $clog2(BTB_DEPTH);
    localparam int SLOT_W = $clog2(FETCH_WIDTH) + 1;

    logic [1:0]       bht        [BHT_DEPTH];
    logic             btb_valid  [BTB_DEPTH];
    logic [TAG_W-1:0] btb_tag    [BTB_DEPTH];
    logic [31:0]      btb_target [BTB_DEPTH];

    logic [31:0]               slot_pc    [FETCH_WIDTH];
    logic [FETCH_WIDTH-1:0]    slot_br;
    logic [FETCH_WIDTH-1:0]    slot_taken;
    logic [32*FETCH_WIDTH-1:0] nxt_pc;
    logic [FETCH_WIDTH-1:0]    nxt_valid;
    logic                      nxt_taken;
    logic [SLOT_W-1:0]         nxt_slot;
    logic [31:0]               nxt_addr;
    logic                      kill;

    logic [BHT_IW-1:0] upd_bht_idx;
    logic [BTB_IW-1:0] upd_btb_idx;
    logic              unused_upd_pc;

    function automatic logic is_branch_op(input logic [5:0] op);
        return (op >= 6'b010010) && (op <= 6'b011011);
    endfunction

    always_comb begin
        nxt_pc = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            slot_pc[i]           = bus.pc_i + 32'(4 * i);
            nxt_pc[32*i +: 32]   = slot_pc[i];
            slot_br[i]           = is_branch_op(bus.inst_i[32*i+26 +: 6]);
            slot_taken[i]        = bus.inst_valid_i[i] && slot_br[i] && !bus.excp_i
                                 && bht[slot_pc[i][BHT_IW+1:2]][1]
                                 && btb_valid[slot_pc[i][BTB_IW+1:2]]
                                 && (btb_tag[slot_pc[i][BTB_IW+1:2]] ==
                                     slot_pc[i][TAG_W+BTB_IW+1:BTB_IW+2]);
        end
    end

    // Lowest predicted-taken slot wins; everything after it is squashed.
    always_comb begin
        kill      = 1'b0;
        nxt_taken = 1'b0;
        nxt_slot  = '0;
        nxt_addr  = bus.pc_i + 32'(4 * FETCH_WIDTH);
        nxt_valid = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            nxt_valid[i] = bus.inst_valid_i[i] && !kill;
            if (!kill && slot_taken[i]) begin
                kill      = 1'b1;
                nxt_taken = 1'b1;
                nxt_slot  = SLOT_W'(i);
                nxt_addr  = btb_target[slot_pc[i][BTB_IW+1:2]];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.inst_o          <= '0;
            bus.pc_o            <= '0;
            bus.valid_o         <= '0;
            bus.is_branch_o     <= '0;
            bus.excp_o          <= 1'b0;
            bus.excp_cause_o    <= '0;
            bus.pre_taken_o     <= 1'b0;
            bus.pre_slot_o      <= '0;
            bus.pre_branch_addr <= '0;
        end else if (bus.branch_flush) begin
            bus.valid_o     <= '0;
            bus.is_branch_o <= '0;
            bus.pre_taken_o <= 1'b0;
            bus.excp_o      <= 1'b0;
        end else if (!bus.stall_i) begin
            bus.inst_o          <= bus.inst_i;
            bus.pc_o            <= nxt_pc;
            bus.valid_o         <= nxt_valid;
            bus.is_branch_o     <= slot_br;
            bus.excp_o          <= bus.excp_i;
            bus.excp_cause_o    <= bus.excp_cause_i;
            bus.pre_taken_o     <= nxt_taken;
            bus.pre_slot_o      <= nxt_slot;
            bus.pre_branch_addr <= nxt_addr;
        end
    end

    assign upd_bht_idx   = bus.upd_pc_i[BHT_IW+1:2];
    assign upd_btb_idx   = bus.upd_pc_i[BTB_IW+1:2];
    assign unused_upd_pc = ^bus.upd_pc_i;

    // Training ignores stall/flush; lookups above see the pre-update table contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
            for (int i = 0; i < BTB_DEPTH; i++) btb_valid[i] <= 1'b0;
        end else if (bus.upd_en_i) begin
            if (bus.upd_taken_i) begin
                if (bht[upd_bht_idx] != 2'b11) bht[upd_bht_idx] <= bht[upd_bht_idx] + 2'b01;
                btb_valid[upd_btb_idx] <= 1'b1;
            end else if (bht[upd_bht_idx] != 2'b00) begin
                bht[upd_bht_idx] <= bht[upd_bht_idx] - 2'b01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bus.upd_en_i && bus.upd_taken_i) begin
            btb_tag[upd_btb_idx]    <= bus.upd_pc_i[TAG_W+BTB_IW+1:BTB_IW+2];
            btb_target[upd_btb_idx] <= bus.upd_target_i;
        end
    end
endmodule
